mips_bus_master: RTL
====================

# mips_bus_master

Parametrised Avalon-MM bus master shared by the multicycle MIPS core's requesters (instruction fetch, load/store, and later debug/DMA). It arbitrates NUM_CH request channels onto one Avalon port and converts byte/half/word accesses into lane-aligned byteenable/writedata. It sign/zero-extends read data and supports both fixed-latency and readdatavalid slaves. It replaces the ad-hoc FETCH/MEM bus sequencing inside the CPU, which becomes a client on channels 0 (fetch) and 1 (data).

## Interface
Parameters:
- NUM_CH, 2, number of requester channels (1..8); channel 0 is highest fixed priority.
- ARB_RR, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- USE_RDV, 0, 0 = read data valid on the cycle waitrequest is low; 1 = wait for readdatavalid.

Ports (reset is asynchronous and active-high; single clock):
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_CH  channel has a request.
- req_ready  out  NUM_CH  one-hot; request accepted this cycle.
- req_addr  in  NUM_CH x 32  byte address.
- req_write  in  NUM_CH  1 = store, 0 = load.
- req_size  in  NUM_CH x 2  size code from mips_bus_pkg.
- req_signed  in  NUM_CH  sign-extend load result.
- req_wdata  in  NUM_CH x 32  store data, right-aligned.
- resp_valid  out  NUM_CH  one-hot, one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned or reserved size; qualified by resp_valid.
- address  out  32  word-aligned Avalon address.
- read, write  out  1 each  Avalon commands.
- waitrequest  in  1  slave stall.
- writedata  out  32  lane-placed store data.
- byteenable  out  4  active lanes.
- readdata  in  32  slave read data.
- readdatavalid  in  1  used only when USE_RDV = 1.
- busy  out  1  state is not IDLE.

## Operation
- Lane convention: little-endian. Byte at offset k uses bits [8k+7:8k] and byteenable[k]. Half at offset 0 → 4'b0011; at offset 2 → 4'b1100. Word → 4'b1111.
- Size codes: 00 = byte, 01 = half, 10 = word, 11 = reserved (error).
- Misaligned: half with addr[0] = 1, or word with addr[1:0] ≠ 0. Misaligned or reserved requests are accepted, perform no bus cycle, and respond with resp_err = 1.
- Stores: writedata = req_wdata shifted left by 8 × offset. Non-enabled lanes are 0.
- Loads: the selected lane is shifted down and sign-extended (req_signed = 1) or zero-extended. Word loads pass through unchanged.
- FSM:
  - IDLE: req_ready = grant & req_valid, combinational. On accept, latch channel, address, size, signed and data, then go to CMD (aligned) or RESP (error).
  - CMD: read or write held with stable address, writedata and byteenable while waitrequest = 1. When waitrequest = 0: a store goes to RESP. A load goes to RESP capturing readdata (USE_RDV = 0) or to RDATA (USE_RDV = 1).
  - RDATA: capture readdata on readdatavalid, then go to RESP.
  - RESP: resp_valid[ch] = 1 for one cycle, then go to IDLE.
- Round-robin pointer moves to (granted + 1) mod NUM_CH on accept only. Fixed mode ignores the pointer.
- Simultaneous requests: exactly one is granted. Others keep req_valid asserted and see req_ready = 0. A client must hold its request stable until req_ready.

## Timing
- Reset values: read = write = 0, address = 0, writedata = 0, byteenable = 0, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, RR pointer = 0, state = IDLE.
- Reset asserted mid-transaction drops read/write immediately (asynchronous). No response is issued.
- Latency from accept cycle (T):
  - Commands assert at T+1.
  - With no wait states, resp_valid at T+2.
  - Each waitrequest cycle adds 1.
  - USE_RDV adds the readdatavalid delay (minimum 1).
  - Error path: resp_valid at T+1.
- Earliest next accept is the cycle after RESP, i.e. throughput of one transaction per 3 cycles minimum.
- readdatavalid outside RDATA is ignored.

## Structure
- mips_bus_pkg holds:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - state_t enum (IDLE, CMD, RDATA, RESP);
  - functions lane_be(size, off), lane_wdata(size, off, d) and lane_rdata(size, off, signed, d);
  - misaligned(size, addr).
- Sub-module mips_bus_arbiter (NUM_CH, ARB_RR): inputs req_valid, advance, pointer state; output one-hot grant.

## Test plan
- Word load, addr 0xBFC00000, readdata 0x8C020004, no waits → address 0xBFC00000, byteenable 1111, resp_valid at T+2, resp_rdata 0x8C020004.
- Signed byte load, addr 0x103, readdata 0x80FF1234 → byteenable 1000, rdata 0xFFFFFF80. Repeat unsigned → 0x00000080.
- Half store, addr 0x12, wdata 0x0000BEEF, waitrequest high 3 cycles → write held 4 cycles, writedata 0xBEEF0000, byteenable 1100, resp at T+5.
- Ch0 and ch1 both valid, ARB_RR = 1, three back-to-back rounds → grants 0, 1, 0. With ARB_RR = 0 → 0, 0, 0.
- Word load at 0x06 → no read pulse, resp_err = 1 at T+1. Reset asserted during CMD wait → read falls asynchronously, busy = 0, no resp_valid.
- USE_RDV = 1, readdatavalid 4 cycles after accept with 0x12345678 → resp_valid the following cycle with that value.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and lane helpers for the MIPS Avalon bus master.
// Little-endian lane placement, extension and alignment checks.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDATA,
    RESP
  } state_t;

  function automatic logic [3:0] lane_be(
    input size_t      size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      SZ_RSVD: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(
    input size_t       size,
    input logic [1:0]  off,
    input logic [31:0] d
  );
    logic [31:0] w;
    w = '0;
    unique case (size)
      SZ_BYTE: w = {24'd0, d[7:0]} << {off, 3'b000};
      SZ_HALF: w = {16'd0, d[15:0]} << {off[1], 4'b0000};
      SZ_WORD: w = d;
      SZ_RSVD: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] lane_rdata(
    input size_t       size,
    input logic [1:0]  off,
    input logic        sgn,
    input logic [31:0] d
  );
    logic [31:0] s;
    logic [31:0] r;
    s = d >> {off, 3'b000};
    r = '0;
    unique case (size)
      SZ_BYTE: r = {{24{sgn & s[7]}}, s[7:0]};
      SZ_HALF: r = {{16{sgn & s[15]}}, s[15:0]};
      SZ_WORD: r = d;
      SZ_RSVD: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(
    input size_t      size,
    input logic [1:0] addr
  );
    return ((size == SZ_HALF) && addr[0]) ||
           ((size == SZ_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/mips_bus_arbiter.sv
// Request arbiter: fixed lowest-index priority or round-robin.
// The RR pointer moves past the winner only when a grant is taken.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ARB_RR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_valid,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PW-1:0] ptr_q, ptr_d, nxt;
  logic          found;
  int            idx;

  // scan from the pointer (RR) or from channel 0 (fixed)
  always_comb begin
    grant = '0;
    found = 1'b0;
    nxt   = ptr_q;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_RR != 0) idx = (int'(ptr_q) + i) % NUM_CH;
      else             idx = i;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        nxt        = PW'((idx + 1) % NUM_CH);
      end
    end
    ptr_d = ptr_q;
    if (advance && found && (ARB_RR != 0)) ptr_d = nxt;
  end

  // round-robin pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mips_bus_master.sv
// Avalon-MM master shared by the core's fetch and load/store clients.
// One transaction at a time: IDLE -> CMD [-> RDATA] -> RESP.
module mips_bus_master
  import mips_bus_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ARB_RR  = 0,
  parameter int USE_RDV = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      req_valid,
  output logic [NUM_CH-1:0]      req_ready,
  input  logic [NUM_CH-1:0][31:0] req_addr,
  input  logic [NUM_CH-1:0]      req_write,
  input  logic [NUM_CH-1:0][1:0] req_size,
  input  logic [NUM_CH-1:0]      req_signed,
  input  logic [NUM_CH-1:0][31:0] req_wdata,
  output logic [NUM_CH-1:0]      resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic [31:0]            address,
  output logic                   read,
  output logic                   write,
  input  logic                   waitrequest,
  output logic [31:0]            writedata,
  output logic [3:0]             byteenable,
  input  logic [31:0]            readdata,
  input  logic                   readdatavalid,
  output logic                   busy
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t        state_q, state_d;
  logic [PW-1:0] ch_q, ch_d, gidx;
  logic [31:0]   addr_q, addr_d;
  logic          wr_q, wr_d;
  size_t         size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   rd_q, rd_d;
  logic          err_q, err_d;

  logic [NUM_CH-1:0] grant;
  logic              accept;
  size_t             req_sz;
  logic [1:0]        req_off;
  logic              req_bad;

  assign accept = (state_q == IDLE) && |(grant & req_valid);

  mips_bus_arbiter #(
    .NUM_CH (NUM_CH),
    .ARB_RR (ARB_RR)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .advance   (accept),
    .grant     (grant)
  );

  // one-hot grant to channel index
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
  end

  assign req_sz  = size_t'(req_size[gidx]);
  assign req_off = req_addr[gidx][1:0];
  assign req_bad = misaligned(req_sz, req_off) ||
                   (req_sz == SZ_RSVD);

  // next-state and latched transaction fields
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    be_d    = be_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ch_d   = gidx;
          addr_d = req_addr[gidx];
          wr_d   = req_write[gidx];
          size_d = req_sz;
          sgn_d  = req_signed[gidx];
          err_d  = req_bad;
          rd_d   = '0;
          be_d   = req_bad ? 4'b0000 :
                   lane_be(req_sz, req_off);
          wd_d   = (req_bad || !req_write[gidx]) ? '0 :
                   lane_wdata(req_sz, req_off,
                              req_wdata[gidx]);
          state_d = req_bad ? RESP : CMD;
        end
      end
      CMD: begin
        if (!waitrequest) begin
          if (wr_q) begin
            state_d = RESP;
          end else if (USE_RDV != 0) begin
            state_d = RDATA;
          end else begin
            rd_d    = lane_rdata(size_q, addr_q[1:0],
                                 sgn_q, readdata);
            state_d = RESP;
          end
        end
      end
      RDATA: begin
        if (readdatavalid) begin
          rd_d    = lane_rdata(size_q, addr_q[1:0],
                               sgn_q, readdata);
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  // state and transaction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // one-cycle response pulse to the owning channel
  always_comb begin
    resp_valid = '0;
    if (state_q == RESP) resp_valid[ch_q] = 1'b1;
  end

  assign req_ready  = (state_q == IDLE) ? (grant & req_valid) : '0;
  assign read       = (state_q == CMD) && !wr_q;
  assign write      = (state_q == CMD) && wr_q;
  assign address    = {addr_q[31:2], 2'b00};
  assign writedata  = wd_q;
  assign byteenable = be_q;
  assign resp_rdata = rd_q;
  assign resp_err   = err_q && (state_q == RESP);
  assign busy       = (state_q != IDLE);

endmodule
